// File: rtl/vx_vec_uop_sequencer.sv
// Expands vector instructions into per-lane dispatch beats and passes scalars through as one beat.
// Output is registered one cycle after accept at 1 beat/cycle; optional perf counters under VX_VSEQ_PERF_EN.
module vx_vec_uop_sequencer #(
  parameter int PAYLOAD_W  = 256,
  parameter int NR_BITS    = 6,
  parameter int MAX_LANES  = 8,
  localparam int LANE_W    = $clog2(MAX_LANES)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [PAYLOAD_W-1:0] in_payload,
  input  logic                 in_is_vec,
  input  logic [NR_BITS-1:0]   in_vd,
  input  logic [LANE_W-1:0]    in_vlanes_m1,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic                 out_is_vec,
  output logic [NR_BITS-1:0]   out_vd,
  output logic [NR_BITS-1:0]   out_vd_lane_id,
  output logic                 out_vd_is_last,
  input  logic                 out_ready
`ifdef VX_VSEQ_PERF_EN
  ,
  output logic [31:0]          perf_beats,
  output logic [31:0]          perf_instrs,
  output logic [31:0]          perf_stalls
`endif
);

  typedef enum logic {IDLE, SEQ} state_e;

  state_e               state_q, state_d;
  logic [PAYLOAD_W-1:0] payload_q, payload_d;
  logic                 is_vec_q, is_vec_d;
  logic [NR_BITS-1:0]   vd_q, vd_d;
  logic [LANE_W-1:0]    lane_q, lane_d;
  logic [LANE_W-1:0]    last_lane_q, last_lane_d;
  logic                 is_last_q, is_last_d;
  logic [LANE_W-1:0]    lane_inc;
  logic                 in_fire, out_fire;

  assign out_fire = (state_q == SEQ) && out_ready;
  assign in_fire  = in_valid && in_ready;
  assign lane_inc = lane_q + LANE_W'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_fire) state_d = SEQ;
      SEQ:     if (out_fire && is_last_q && !in_fire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // in_ready looks through out_ready so the next instruction loads on the last beat with no bubble.
  always_comb begin
    out_valid = (state_q == SEQ);
    in_ready  = (state_q == IDLE) || (out_fire && is_last_q);
  end

  always_comb begin
    payload_d   = payload_q;
    is_vec_d    = is_vec_q;
    vd_d        = vd_q;
    lane_d      = lane_q;
    last_lane_d = last_lane_q;
    is_last_d   = is_last_q;
    if (in_fire) begin
      payload_d   = in_payload;
      is_vec_d    = in_is_vec;
      vd_d        = in_vd;
      lane_d      = '0;
      last_lane_d = in_is_vec ? in_vlanes_m1 : '0;
      is_last_d   = in_is_vec ? (in_vlanes_m1 == '0) : 1'b1;
    end else if (out_fire && !is_last_q) begin
      lane_d    = lane_inc;
      is_last_d = (lane_inc == last_lane_q);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      payload_q   <= '0;
      is_vec_q    <= 1'b0;
      vd_q        <= '0;
      lane_q      <= '0;
      last_lane_q <= '0;
      is_last_q   <= 1'b0;
    end else begin
      payload_q   <= payload_d;
      is_vec_q    <= is_vec_d;
      vd_q        <= vd_d;
      lane_q      <= lane_d;
      last_lane_q <= last_lane_d;
      is_last_q   <= is_last_d;
    end
  end

  assign out_payload    = payload_q;
  assign out_is_vec     = is_vec_q;
  assign out_vd         = vd_q;
  assign out_vd_lane_id = NR_BITS'(lane_q);
  assign out_vd_is_last = is_last_q;

`ifdef VX_VSEQ_PERF_EN
  logic [31:0] beats_q, instrs_q, stalls_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      beats_q  <= '0;
      instrs_q <= '0;
      stalls_q <= '0;
    end else begin
      if (out_fire)               beats_q  <= beats_q + 32'd1;
      if (in_fire)                instrs_q <= instrs_q + 32'd1;
      if (out_valid && !out_ready) stalls_q <= stalls_q + 32'd1;
    end
  end

  assign perf_beats  = beats_q;
  assign perf_instrs = instrs_q;
  assign perf_stalls = stalls_q;
`endif

endmodule
